// File: rtl/hilo_muldiv_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_if
// Purpose  : Control strobes, operands and HI/LO results of the mul/div unit.
// Revision : 1.0
// ============================================================================
interface hilo_muldiv_if;
  logic        mult;
  logic        multu;
  logic        div;
  logic        divu;
  logic        mthi;
  logic        mtlo;
  logic        mfhi;
  logic        mflo;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;
  logic        busy;
  logic        stall;

  modport master (
    output mult, multu, div, divu, mthi, mtlo, mfhi, mflo, a, b,
    input  hi, lo, rdata, busy, stall
  );

  modport slave (
    input  mult, multu, div, divu, mthi, mtlo, mfhi, mflo, a, b,
    output hi, lo, rdata, busy, stall
  );
endinterface
`default_nettype wire

// File: rtl/hilo_muldiv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv
// Purpose  : HI/LO owner with bit-serial multiply/divide and pipeline stall.
//            Define FAST_MULT_EN for a single-edge combinational multiply.
// Revision : 1.0
// ============================================================================
module hilo_muldiv #(
  parameter int MD_CYCLES = 32
) (
  input  wire logic    clk,
  input  wire logic    reset,
  hilo_muldiv_if.slave md
);
  localparam int                 c_CNT_W    = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

`ifdef FAST_MULT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;
`endif

  state_t              r_state;
  state_t              w_state_n;
  logic [31:0]         r_hi;
  logic [31:0]         r_lo;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_dvz;
  logic [31:0]         r_a_orig;
  logic [31:0]         r_dvsr;
  logic [31:0]         r_rem;
  logic [31:0]         r_quo;

  logic                w_div_go;
  logic                w_mul_go;
  logic                w_op_signed;
  logic [31:0]         w_abs_a;
  logic [31:0]         w_abs_b;
  logic                w_last;
  logic [32:0]         w_shift;
  logic [32:0]         w_trial;
  logic                w_ge;
  logic [31:0]         w_rem_n;
  logic [31:0]         w_quo_n;

  assign w_div_go    = md.div | md.divu;
  assign w_mul_go    = md.mult | md.multu;
  // div outranks divu and mult outranks multu, so the higher strobe sets signedness
  assign w_op_signed = w_div_go ? md.div : md.mult;
  assign w_abs_a     = (w_op_signed && md.a[31]) ? (32'd0 - md.a) : md.a;
  assign w_abs_b     = (w_op_signed && md.b[31]) ? (32'd0 - md.b) : md.b;
  assign w_last      = (r_cnt == c_CNT_LAST);

  // Restoring step; a set shifted MSB already guarantees the divisor fits
  assign w_shift = {r_rem, r_quo[31]};
  assign w_trial = w_shift - {1'b0, r_dvsr};
  assign w_ge    = w_shift[32] | ~w_trial[32];
  assign w_rem_n = w_ge ? w_trial[31:0] : w_shift[31:0];
  assign w_quo_n = {r_quo[30:0], w_ge};

`ifdef FAST_MULT_EN
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_fast_prod;

  assign w_ext_a     = {{32{md.mult & md.a[31]}}, md.a};
  assign w_ext_b     = {{32{md.mult & md.b[31]}}, md.b};
  assign w_fast_prod = w_ext_a * w_ext_b;
`else
  logic [63:0] r_acc;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [63:0] w_acc_n;

  assign w_acc_n = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_div_go) begin
          w_state_n = S_DIV;
`ifndef FAST_MULT_EN
        end else if (w_mul_go) begin
          w_state_n = S_MUL;
`endif
        end
      end
`ifndef FAST_MULT_EN
      S_MUL:   if (w_last) w_state_n = S_IDLE;
`endif
      S_DIV:   if (w_last) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dvz    <= 1'b0;
      r_a_orig <= '0;
      r_dvsr   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
`ifndef FAST_MULT_EN
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_div_go || w_mul_go) begin
            r_neg_q <= w_op_signed & (md.a[31] ^ md.b[31]);
            r_neg_r <= w_op_signed & md.a[31];
          end
          if (w_div_go) begin
            r_a_orig <= md.a;
            r_dvz    <= (md.b == 32'd0);
            r_dvsr   <= w_abs_b;
            r_rem    <= '0;
            r_quo    <= w_abs_a;
          end else if (w_mul_go) begin
`ifdef FAST_MULT_EN
            {r_hi, r_lo} <= w_fast_prod;
`else
            r_acc    <= '0;
            r_mcand  <= {32'd0, w_abs_a};
            r_mplier <= w_abs_b;
`endif
          end else if (md.mthi) begin
            r_hi <= md.a;
          end else if (md.mtlo) begin
            r_lo <= md.a;
          end
        end
`ifndef FAST_MULT_EN
        S_MUL: begin
          r_cnt    <= r_cnt + c_CNT_ONE;
          r_acc    <= w_acc_n;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (w_last) begin
            {r_hi, r_lo} <= r_neg_q ? (64'd0 - w_acc_n) : w_acc_n;
          end
        end
`endif
        S_DIV: begin
          r_cnt <= r_cnt + c_CNT_ONE;
          r_rem <= w_rem_n;
          r_quo <= w_quo_n;
          if (w_last) begin
            if (r_dvz) begin
              r_lo <= '1;
              r_hi <= r_a_orig;
            end else begin
              r_lo <= r_neg_q ? (32'd0 - w_quo_n) : w_quo_n;
              r_hi <= r_neg_r ? (32'd0 - w_rem_n) : w_rem_n;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign md.hi    = r_hi;
  assign md.lo    = r_lo;
  assign md.busy  = (r_state != S_IDLE);
  assign md.rdata = md.mfhi ? r_hi : r_lo;
  assign md.stall = md.busy & (md.mult | md.multu | md.div | md.divu |
                               md.mthi | md.mtlo | md.mfhi | md.mflo);
endmodule
`default_nettype wire
